// File: rtl/pacman_pkg.sv
// Shared Pac-Man display definitions: directions, screen size, colours and
// the procedural ghost sprite used to fill the sprite ROM.
package pacman_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam logic [11:0] RGB_BLACK = 12'h000;
  localparam logic [11:0] RGB_WHITE = 12'hFFF;
  localparam logic [11:0] RGB_PUPIL = 12'h00F;

  typedef enum logic [1:0] {
    PIX_TRANSP = 2'd0,
    PIX_BODY   = 2'd1,
    PIX_EYE    = 2'd2,
    PIX_PUPIL  = 2'd3
  } pix_code_e;

  // 16x16 ghost: rounded dome, two 3x4 eye whites, a 1x2 pupil that looks
  // towards dir, and a skirt on row 15 whose teeth shift with the anim phase.
  function automatic pix_code_e sprite_code(input logic [1:0] dir, input logic phase,
                                            input logic [3:0] r, input logic [3:0] c);
    logic       body;
    logic       in_eye;
    logic [3:0] ec;
    logic [3:0] pr0;
    logic [3:0] pc;
    sprite_code = PIX_TRANSP;
    in_eye = (r >= 4'd5) && (r <= 4'd8) &&
             (((c >= 4'd3) && (c <= 4'd5)) || ((c >= 4'd10) && (c <= 4'd12)));
    ec = (c >= 4'd10) ? (c - 4'd10) : (c - 4'd3);
    case (dir)
      DIR_UP:   begin pr0 = 4'd5; pc = 4'd1; end
      DIR_DOWN: begin pr0 = 4'd7; pc = 4'd1; end
      DIR_LEFT: begin pr0 = 4'd6; pc = 4'd0; end
      default:  begin pr0 = 4'd6; pc = 4'd2; end
    endcase
    if (r == 4'd0)       body = (c >= 4'd4) && (c <= 4'd11);
    else if (r == 4'd1)  body = (c >= 4'd2) && (c <= 4'd13);
    else if (r == 4'd15) body = (c[1] == phase);
    else                 body = 1'b1;
    if (in_eye)
      sprite_code = (((r == pr0) || (r == pr0 + 4'd1)) && (ec == pc)) ? PIX_PUPIL : PIX_EYE;
    else if (body)
      sprite_code = PIX_BODY;
  endfunction

endpackage

// File: rtl/ghost_sprite_renderer_if.sv
// Pixel-stream bus between the VGA timing generator, the ghost movement block
// and one ghost renderer.
interface ghost_sprite_renderer_if;
  import pacman_pkg::*;

  // pix_valid qualifies pix_x/pix_y in the same cycle; out_valid is pix_valid
  // delayed two cycles. There is no ready: the renderer accepts every cycle.
  logic                         frame_start;
  logic                         pix_valid;
  logic [$clog2(SCREEN_W)-1:0]  pix_x;
  logic [$clog2(SCREEN_H)-1:0]  pix_y;
  logic [$clog2(SCREEN_W)-1:0]  ghost_x;
  logic [$clog2(SCREEN_H)-1:0]  ghost_y;
  logic [1:0]                   ghost_dir;
  logic                         out_valid;
  logic                         pix_hit;
  logic [11:0]                  pix_rgb;

  modport master (
    output frame_start, pix_valid, pix_x, pix_y, ghost_x, ghost_y, ghost_dir,
    input  out_valid, pix_hit, pix_rgb
  );

  modport slave (
    input  frame_start, pix_valid, pix_x, pix_y, ghost_x, ghost_y, ghost_dir,
    output out_valid, pix_hit, pix_rgb
  );

endinterface

// File: rtl/ghost_sprite_rom.sv
// One-cycle synchronous sprite ROM, address {dir, phase, row, col}, 2-bit codes.
module ghost_sprite_rom
  import pacman_pkg::*;
#(
  parameter int SPR_W = 16,
  parameter int SPR_H = 16,
  localparam int CW = $clog2(SPR_W),
  localparam int RW = $clog2(SPR_H),
  localparam int AW = 3 + RW + CW
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output pix_code_e     code
);

  logic [1:0]    dir;
  logic          phase;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [3:0]    row16;
  logic [3:0]    col16;

  assign {dir, phase, row, col} = addr;

  // The art is drawn on a 16x16 grid; other sprite sizes sample it nearest-neighbour.
  assign row16 = 4'((int'(row) * 16) / SPR_H);
  assign col16 = 4'((int'(col) * 16) / SPR_W);

  always_ff @(posedge clk) begin
    code <= sprite_code(dir, phase, row16, col16);
  end

endmodule

// File: rtl/ghost_sprite_renderer.sv
// Per-ghost renderer: frame-latched ghost state, animation counter, box test,
// sprite ROM lookup and colour map in a fixed two-cycle pixel pipeline.
module ghost_sprite_renderer
  import pacman_pkg::*;
#(
  parameter int          SPR_W       = 16,
  parameter int          SPR_H       = 16,
  parameter int          ANIM_FRAMES = 8,
  parameter logic [11:0] BODY_RGB    = 12'hF0F,
  parameter logic [9:0]  RST_X       = 10'd595,
  parameter logic [8:0]  RST_Y       = 9'd435
) (
  input  logic clk,
  input  logic rst,
  ghost_sprite_renderer_if.slave bus
);

  localparam int CW    = $clog2(SPR_W);
  localparam int RW    = $clog2(SPR_H);
  localparam int AW    = 3 + RW + CW;
  localparam int CNT_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(ANIM_FRAMES - 1);
  localparam logic signed [10:0] HALF_W   = 11'(SPR_W / 2);
  localparam logic signed [10:0] HALF_H   = 11'(SPR_H / 2);

  logic [9:0]       shadow_x;
  logic [8:0]       shadow_y;
  logic [1:0]       shadow_dir;
  logic [CNT_W-1:0] frame_cnt;
  logic             anim_phase;

  logic signed [10:0] dx;
  logic signed [10:0] dy;
  logic               in_box;
  logic [AW-1:0]      rom_addr;
  pix_code_e          code;
  logic               in_box_d;
  logic               valid_d;
  logic [11:0]        colour;
  logic               hit_next;

  // Ghost state is sampled only at frame_start so a frame never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_x   <= RST_X;
      shadow_y   <= RST_Y;
      shadow_dir <= DIR_LEFT;
      frame_cnt  <= '0;
      anim_phase <= 1'b0;
    end else if (bus.frame_start) begin
      shadow_x   <= bus.ghost_x;
      shadow_y   <= bus.ghost_y;
      shadow_dir <= bus.ghost_dir;
      if (frame_cnt == CNT_LAST) begin
        frame_cnt  <= '0;
        anim_phase <= ~anim_phase;
      end else begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

  // Signed offsets into the sprite box; negatives clip instead of wrapping.
  assign dx = $signed({1'b0, bus.pix_x}) - $signed({1'b0, shadow_x}) + HALF_W;
  assign dy = $signed({2'b0, bus.pix_y}) - $signed({2'b0, shadow_y}) + HALF_H;
  assign in_box = bus.pix_valid
                  && !dx[10] && (dx[9:0] < 10'(SPR_W))
                  && !dy[10] && (dy[9:0] < 10'(SPR_H));
  assign rom_addr = {shadow_dir, anim_phase, dy[RW-1:0], dx[CW-1:0]};

  ghost_sprite_rom #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .code (code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      in_box_d <= 1'b0;
      valid_d  <= 1'b0;
    end else begin
      in_box_d <= in_box;
      valid_d  <= bus.pix_valid;
    end
  end

  always_comb begin
    colour = RGB_BLACK;
    case (code)
      PIX_BODY:  colour = BODY_RGB;
      PIX_EYE:   colour = RGB_WHITE;
      PIX_PUPIL: colour = RGB_PUPIL;
      default:   colour = RGB_BLACK;
    endcase
  end

  assign hit_next = in_box_d && (code != PIX_TRANSP);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.pix_hit   <= 1'b0;
      bus.pix_rgb   <= RGB_BLACK;
    end else begin
      bus.out_valid <= valid_d;
      bus.pix_hit   <= hit_next;
      bus.pix_rgb   <= hit_next ? colour : RGB_BLACK;
    end
  end

endmodule

// File: tb/tb_ghost_sprite_renderer.sv
// Self-checking bench for ghost_sprite_renderer: directed scenarios plus random
// pixel streams against a character-art reference model of the ghost.
module tb_ghost_sprite_renderer;

  localparam logic [11:0] BODY = 12'hF0F;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ghost_sprite_renderer_if bus ();

  ghost_sprite_renderer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference sprite: B body, W eye white, . transparent; pupils overlaid per direction.
  string body_art [15] = '{
    "....BBBBBBBB....",
    "..BBBBBBBBBBBB..",
    "BBBBBBBBBBBBBBBB",
    "BBBBBBBBBBBBBBBB",
    "BBBBBBBBBBBBBBBB",
    "BBBWWWBBBBWWWBBB",
    "BBBWWWBBBBWWWBBB",
    "BBBWWWBBBBWWWBBB",
    "BBBWWWBBBBWWWBBB",
    "BBBBBBBBBBBBBBBB",
    "BBBBBBBBBBBBBBBB",
    "BBBBBBBBBBBBBBBB",
    "BBBBBBBBBBBBBBBB",
    "BBBBBBBBBBBBBBBB",
    "BBBBBBBBBBBBBBBB"
  };
  string skirt_art [2] = '{"BB..BB..BB..BB..", "..BB..BB..BB..BB"};
  int pup_row [4] = '{5, 7, 6, 6};
  int pup_col [4] = '{1, 1, 0, 2};

  int m_x, m_y, m_dir, m_cnt, m_phase;
  logic [13:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {valid,hit,rgb}=%h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic byte sprite_char(input int dir, input int ph, input int r, input int c);
    byte ch;
    ch = (r < 15) ? body_art[r].getc(c) : skirt_art[ph].getc(c);
    if (ch == "W" && (r == pup_row[dir] || r == pup_row[dir] + 1) &&
        (c == 3 + pup_col[dir] || c == 10 + pup_col[dir]))
      ch = "P";
    return ch;
  endfunction

  function automatic logic [13:0] model_pixel(input logic pv, input int px, input int py);
    int dx, dy;
    byte ch;
    dx = px - m_x + 8;
    dy = py - m_y + 8;
    if (!pv) return 14'h0;
    if (dx < 0 || dx > 15 || dy < 0 || dy > 15) return {2'b10, 12'h000};
    ch = sprite_char(m_dir, m_phase, dy, dx);
    case (ch)
      "B":     return {2'b11, BODY};
      "W":     return {2'b11, 12'hFFF};
      "P":     return {2'b11, 12'h00F};
      default: return {2'b10, 12'h000};
    endcase
  endfunction

  task automatic model_reset();
    m_x = 595; m_y = 435; m_dir = 2; m_cnt = 0; m_phase = 0;
  endtask

  task automatic set_ghost(input int gx, input int gy, input int gd);
    bus.ghost_x = 10'(gx);
    bus.ghost_y = 9'(gy);
    bus.ghost_dir = 2'(gd);
  endtask

  // One clock of stimulus; outputs seen after the edge belong to the previous pixel.
  task automatic drive(input string tag, input logic fs, input logic pv, input int px, input int py);
    logic [13:0] e;
    bus.frame_start = fs;
    bus.pix_valid = pv;
    bus.pix_x = 10'(px);
    bus.pix_y = 9'(py);
    exp_q.push_back(model_pixel(pv, px, py));
    if (fs) begin
      m_x = int'(bus.ghost_x);
      m_y = int'(bus.ghost_y);
      m_dir = int'(bus.ghost_dir);
      if (m_cnt == 7) begin m_cnt = 0; m_phase = 1 - m_phase; end
      else m_cnt++;
    end
    @(posedge clk);
    #1;
    if (exp_q.size() == 2) begin
      e = exp_q.pop_front();
      check(tag, {bus.out_valid, bus.pix_hit, bus.pix_rgb}, e);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    bus.frame_start = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      check("reset_out", {bus.out_valid, bus.pix_hit, bus.pix_rgb}, 14'h0);
    end
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(14'h0);
    model_reset();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive("idle", 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    int px, py;
    bus.frame_start = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_x = '0;
    bus.pix_y = '0;
    set_ghost(100, 100, 0);

    // Reset, then the first frame_start pixel still sees the reset shadow.
    do_reset(2);
    drive("reset_shadow_fs", 1'b1, 1'b1, 595, 435);
    drive("after_latch", 1'b0, 1'b1, 595, 435);
    drive("after_latch_new", 1'b0, 1'b1, 100, 100);

    // Latch and tear-free hold.
    set_ghost(200, 146, 3);
    drive("latch_fs", 1'b1, 1'b0, 0, 0);
    drive("centre", 1'b0, 1'b1, 200, 146);
    set_ghost(300, 146, 0);
    for (int i = 0; i < 3; i++) drive("hold_mid_frame", 1'b0, 1'b1, 200, 146);
    drive("hold_not_new", 1'b0, 1'b1, 300, 146);
    set_ghost(200, 146, 3);
    drive("relatch_fs", 1'b1, 1'b0, 0, 0);

    // Box edges on all four sides.
    drive("bound_tl", 1'b0, 1'b1, 192, 138);
    drive("bound_br", 1'b0, 1'b1, 207, 153);
    drive("bound_left_in", 1'b0, 1'b1, 192, 146);
    drive("bound_left_out", 1'b0, 1'b1, 191, 146);
    drive("bound_tl_out", 1'b0, 1'b1, 191, 138);
    drive("bound_right_in", 1'b0, 1'b1, 207, 146);
    drive("bound_right_out", 1'b0, 1'b1, 208, 146);
    drive("bound_top_in", 1'b0, 1'b1, 200, 138);
    drive("bound_top_out", 1'b0, 1'b1, 200, 137);
    drive("bound_bot_in", 1'b0, 1'b1, 200, 153);
    drive("bound_bot_out", 1'b0, 1'b1, 200, 154);
    drive("invalid_in_box", 1'b0, 1'b0, 200, 146);

    // Clipping near the origin; the far corner must not wrap.
    set_ghost(4, 4, 1);
    drive("clip_fs", 1'b1, 1'b0, 0, 0);
    drive("clip_origin", 1'b0, 1'b1, 0, 0);
    drive("clip_edge_x", 1'b0, 1'b1, 0, 11);
    drive("clip_edge_y", 1'b0, 1'b1, 11, 0);
    drive("clip_out", 1'b0, 1'b1, 12, 12);
    drive("clip_far", 1'b0, 1'b1, 639, 479);

    // Animation: skirt row and eye row after each of 17 frame pulses.
    for (int p = 0; p < 17; p++) begin
      set_ghost(200, 146, p % 4);
      drive("anim_fs", 1'b1, 1'b0, 0, 0);
      for (int c = 0; c < 16; c++) drive("anim_row15", 1'b0, 1'b1, 192 + c, 153);
      for (int c = 0; c < 16; c++) drive("anim_row6", 1'b0, 1'b1, 192 + c, 144);
    end

    // Same-cycle frame_start and box pixel: old shadow applies.
    set_ghost(400, 300, 2);
    drive("simul_fs", 1'b1, 1'b1, 200, 146);
    drive("simul_after", 1'b0, 1'b1, 400, 300);

    // Random streams with frequent frame pulses.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        if ($urandom_range(0, 3) == 0)
          set_ghost($urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 3));
        else
          set_ghost($urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 3));
      end
      if ($urandom_range(0, 1) == 0) begin
        px = m_x + $urandom_range(0, 23) - 12;
        py = m_y + $urandom_range(0, 23) - 12;
        if (px < 0) px = 0;
        if (px > 639) px = 639;
        if (py < 0) py = 0;
        if (py > 479) py = 479;
      end else begin
        px = $urandom_range(0, 639);
        py = $urandom_range(0, 479);
      end
      drive("random", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), px, py);
    end

    // Reset during a hit run clears the outputs and the shadow.
    set_ghost(200, 146, 0);
    drive("run_fs", 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++) drive("run_hit", 1'b0, 1'b1, 200, 146);
    do_reset(1);
    for (int i = 0; i < 3; i++) drive("post_reset_nohit", 1'b0, 1'b1, 200, 146);
    drive("post_reset_fs", 1'b1, 1'b1, 200, 146);
    drive("post_reset_hit", 1'b0, 1'b1, 200, 146);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
